multicycle_control: RTL and testbench

Main control FSM for the multi-cycle RISC-V datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath mux selects and write strobes, and supplies the 2-bit `aluop` consumed by the downstream ALU control decoder (00 = add, 01 = subtract, 10 = decode from funct3/funct7). Supports lw, sw, R-type and beq, a memory ready handshake, an illegal-opcode trap, and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multicycle_control                                            |
// | Purpose  : Main control FSM for a multi-cycle RISC-V datapath. Steps each |
// |            instruction through fetch / decode / execute / memory /       |
// |            writeback, drives datapath selects and write strobes, issues  |
// |            the aluop class, traps on illegal opcodes and counts retired  |
// |            instructions.                                                 |
// | Ports    : clk, rst            - clock, synchronous active-high reset    |
// |            i_opcode            - instr[6:0], sampled in DECODE/MEMADR    |
// |            i_zero              - ALU zero flag (branch decision)         |
// |            i_mem_ready         - memory access completes this cycle      |
// |            o_mem_req/o_adr_src - memory request and address select       |
// |            o_ir_write/o_pc_write/o_mem_write/o_reg_write - strobes       |
// |            o_alu_src_a/b, o_result_src, o_aluop - datapath selects       |
// |            o_trap, o_state     - halt indication, debug state            |
// |            o_instr_count       - retired-instruction counter             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         i_opcode,
  input  logic               i_zero,
  input  logic               i_mem_ready,
  output logic               o_mem_req,
  output logic               o_adr_src,
  output logic               o_ir_write,
  output logic               o_pc_write,
  output logic               o_mem_write,
  output logic               o_reg_write,
  output logic [1:0]         o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_result_src,
  output logic [1:0]         o_aluop,
  output logic               o_trap,
  output logic [3:0]         o_state,
  output logic [COUNT_W-1:0] o_instr_count
);

  localparam logic [3:0] c_FETCH    = 4'd0;
  localparam logic [3:0] c_DECODE   = 4'd1;
  localparam logic [3:0] c_MEMADR   = 4'd2;
  localparam logic [3:0] c_MEMREAD  = 4'd3;
  localparam logic [3:0] c_MEMWB    = 4'd4;
  localparam logic [3:0] c_MEMWRITE = 4'd5;
  localparam logic [3:0] c_EXECR    = 4'd6;
  localparam logic [3:0] c_ALUWB    = 4'd7;
  localparam logic [3:0] c_BEQ      = 4'd8;
  localparam logic [3:0] c_TRAP     = 4'd15;

  localparam logic [6:0] c_OP_LW    = 7'b0000011;
  localparam logic [6:0] c_OP_SW    = 7'b0100011;
  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

  localparam logic [COUNT_W-1:0] c_COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [3:0]         r_state;
  logic [3:0]         w_next_state;
  logic [COUNT_W-1:0] r_instr_count;
  logic               w_retire;

  // Raw strobes before the reset override.
  logic w_mem_req;
  logic w_ir_write;
  logic w_pc_write;
  logic w_mem_write;
  logic w_reg_write;

  // ------------------------------------------------------------------------
  // State register and retired-instruction counter
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_FETCH;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_instr_count <= r_instr_count + c_COUNT_ONE;
      end
    end
  end

  // An instruction retires on the transition that returns to FETCH.
  // A store retires only once memory accepts it.
  assign w_retire = (r_state == c_MEMWB) || (r_state == c_ALUWB) ||
                    (r_state == c_BEQ)   ||
                    ((r_state == c_MEMWRITE) && i_mem_ready);

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_FETCH: begin
        if (i_mem_ready) w_next_state = c_DECODE;
      end
      c_DECODE: begin
        case (i_opcode)
          c_OP_LW, c_OP_SW: w_next_state = c_MEMADR;
          c_OP_R:           w_next_state = c_EXECR;
          c_OP_BEQ:         w_next_state = c_BEQ;
          default:          w_next_state = c_TRAP;
        endcase
      end
      c_MEMADR: begin
        w_next_state = (i_opcode == c_OP_LW) ? c_MEMREAD : c_MEMWRITE;
      end
      c_MEMREAD: begin
        if (i_mem_ready) w_next_state = c_MEMWB;
      end
      c_MEMWB:    w_next_state = c_FETCH;
      c_MEMWRITE: begin
        if (i_mem_ready) w_next_state = c_FETCH;
      end
      c_EXECR:    w_next_state = c_ALUWB;
      c_ALUWB:    w_next_state = c_FETCH;
      c_BEQ:      w_next_state = c_FETCH;
      c_TRAP:     w_next_state = c_TRAP;
      // Unused encodings halt the machine rather than wander.
      default:    w_next_state = c_TRAP;
    endcase
  end

  // ------------------------------------------------------------------------
  // Output decode (from registered state; only mem_ready and zero gate)
  // ------------------------------------------------------------------------
  always_comb begin
    w_mem_req    = 1'b0;
    o_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_result_src = 2'b00;
    o_aluop      = 2'b00;
    o_trap       = 1'b0;
    case (r_state)
      c_FETCH: begin
        // PC + 4 computed by the ALU and written straight from its result.
        w_mem_req    = 1'b1;
        w_ir_write   = i_mem_ready;
        w_pc_write   = i_mem_ready;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
      end
      c_DECODE: begin
        // Old PC + immediate lands in ALUOut as a speculative branch target.
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
      end
      c_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
      end
      c_MEMREAD: begin
        w_mem_req = 1'b1;
        o_adr_src = 1'b1;
      end
      c_MEMWB: begin
        o_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      c_MEMWRITE: begin
        w_mem_req   = 1'b1;
        o_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_EXECR: begin
        o_alu_src_a = 2'b10;
        o_aluop     = 2'b10;
      end
      c_ALUWB: begin
        w_reg_write = 1'b1;
      end
      c_BEQ: begin
        // Subtract for the compare; target comes from ALUOut.
        o_alu_src_a = 2'b10;
        o_aluop     = 2'b01;
        w_pc_write  = i_zero;
      end
      c_TRAP: begin
        o_trap = 1'b1;
      end
      default: begin
        o_trap = 1'b1;
      end
    endcase
  end

  // Reset suppresses every write/request strobe immediately, in any state.
  assign o_mem_req     = w_mem_req   & ~rst;
  assign o_ir_write    = w_ir_write  & ~rst;
  assign o_pc_write    = w_pc_write  & ~rst;
  assign o_mem_write   = w_mem_write & ~rst;
  assign o_reg_write   = w_reg_write & ~rst;
  assign o_state       = r_state;
  assign o_instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multicycle_control                                         |
// | Purpose  : Self-checking bench for multicycle_control with a behavioural |
// |            instruction-level reference model.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;

  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] r_opcode;
  logic       r_zero;
  logic       r_mem_ready;

  logic        w_mem_req, w_adr_src, w_ir_write, w_pc_write, w_mem_write, w_reg_write;
  logic [1:0]  w_alu_src_a, w_alu_src_b, w_result_src, w_aluop;
  logic        w_trap;
  logic [3:0]  w_state;
  logic [31:0] w_count;

  logic        w4_mem_req, w4_adr_src, w4_ir_write, w4_pc_write, w4_mem_write, w4_reg_write;
  logic [1:0]  w4_alu_src_a, w4_alu_src_b, w4_result_src, w4_aluop;
  logic        w4_trap;
  logic [3:0]  w4_state;
  logic [3:0]  w4_count;

  multicycle_control u_dut (
    .clk(clk), .rst(rst), .i_opcode(r_opcode), .i_zero(r_zero), .i_mem_ready(r_mem_ready),
    .o_mem_req(w_mem_req), .o_adr_src(w_adr_src), .o_ir_write(w_ir_write),
    .o_pc_write(w_pc_write), .o_mem_write(w_mem_write), .o_reg_write(w_reg_write),
    .o_alu_src_a(w_alu_src_a), .o_alu_src_b(w_alu_src_b), .o_result_src(w_result_src),
    .o_aluop(w_aluop), .o_trap(w_trap), .o_state(w_state), .o_instr_count(w_count)
  );

  multicycle_control #(.COUNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_opcode(r_opcode), .i_zero(r_zero), .i_mem_ready(r_mem_ready),
    .o_mem_req(w4_mem_req), .o_adr_src(w4_adr_src), .o_ir_write(w4_ir_write),
    .o_pc_write(w4_pc_write), .o_mem_write(w4_mem_write), .o_reg_write(w4_reg_write),
    .o_alu_src_a(w4_alu_src_a), .o_alu_src_b(w4_alu_src_b), .o_result_src(w4_result_src),
    .o_aluop(w4_aluop), .o_trap(w4_trap), .o_state(w4_state), .o_instr_count(w4_count)
  );

  always #5 clk = ~clk;

  // {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
  //  alu_src_a, alu_src_b, result_src, aluop, trap}
  logic [14:0] w_ctrl;
  assign w_ctrl = {w_mem_req, w_adr_src, w_ir_write, w_pc_write, w_mem_write, w_reg_write,
                   w_alu_src_a, w_alu_src_b, w_result_src, w_aluop, w_trap};

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_count;
  int          mw_cycles;
  int          rw_cycles;

  // Control vector the state table prescribes for a state.
  function automatic logic [14:0] exp_ctrl(input int st, input bit mr, input bit z, input bit in_rst);
    logic req, adr, irw, pcw, mw, rw, trp;
    logic [1:0] a, b, rs, op;
    req = 0; adr = 0; irw = 0; pcw = 0; mw = 0; rw = 0; trp = 0;
    a = 2'b00; b = 2'b00; rs = 2'b00; op = 2'b00;
    case (st)
      0:  begin req = 1; irw = mr; pcw = mr; b = 2'b10; rs = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin req = 1; adr = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin req = 1; adr = 1; mw = 1; end
      6:  begin a = 2'b10; op = 2'b10; end
      7:  begin rw = 1; end
      8:  begin a = 2'b10; op = 2'b01; pcw = z; end
      default: trp = 1;
    endcase
    if (in_rst) begin req = 0; irw = 0; pcw = 0; mw = 0; rw = 0; end
    return {req, adr, irw, pcw, mw, rw, a, b, rs, op, trp};
  endfunction

  function automatic logic [6:0] rand_op();
    return 7'($urandom);
  endfunction

  // One clock of activity: drive, check, then advance to just past the edge.
  task automatic cyc(input int st, input bit mr, input bit z, input logic [6:0] op);
    logic [14:0] e;
    r_mem_ready = mr; r_zero = z; r_opcode = op;
    #1;
    e = exp_ctrl(st, mr, z, 1'b0);
    n_checks++;
    if (w_state !== 4'(st)) begin
      n_fails++; $display("FAIL state: got %0d expected %0d at %0t", w_state, st, $time);
    end
    n_checks++;
    if (w_ctrl !== e) begin
      n_fails++; $display("FAIL ctrl(state %0d): got %b expected %b at %0t", st, w_ctrl, e, $time);
    end
    n_checks++;
    if (w_count !== exp_count) begin
      n_fails++; $display("FAIL count: got %0d expected %0d at %0t", w_count, exp_count, $time);
    end
    n_checks++;
    if (w4_count !== exp_count[3:0]) begin
      n_fails++; $display("FAIL count4: got %0d expected %0d at %0t", w4_count, exp_count[3:0], $time);
    end
    if (w_mem_write === 1'b1) mw_cycles++;
    if (w_reg_write === 1'b1) rw_cycles++;
    @(posedge clk); #1;
    if (st == 4 || st == 7 || st == 8 || (st == 5 && mr)) exp_count = exp_count + 1;
  endtask

  // kind: 0 lw, 1 sw, 2 R-type, 3 beq
  task automatic run_instr(input int kind, input bit z, input int fwait, input int mwait);
    logic [6:0] op;
    case (kind)
      0: op = c_OP_LW;
      1: op = c_OP_SW;
      2: op = c_OP_R;
      default: op = c_OP_BEQ;
    endcase
    for (int i = 0; i < fwait; i++) cyc(0, 1'b0, 1'($urandom), rand_op());
    cyc(0, 1'b1, 1'($urandom), rand_op());
    cyc(1, 1'($urandom), 1'($urandom), op);
    case (kind)
      0: begin
        cyc(2, 1'($urandom), 1'($urandom), op);
        for (int i = 0; i < mwait; i++) cyc(3, 1'b0, 1'($urandom), rand_op());
        cyc(3, 1'b1, 1'($urandom), rand_op());
        cyc(4, 1'($urandom), 1'($urandom), rand_op());
      end
      1: begin
        cyc(2, 1'($urandom), 1'($urandom), op);
        for (int i = 0; i < mwait; i++) cyc(5, 1'b0, 1'($urandom), rand_op());
        cyc(5, 1'b1, 1'($urandom), rand_op());
      end
      2: begin
        cyc(6, 1'($urandom), 1'($urandom), rand_op());
        cyc(7, 1'($urandom), 1'($urandom), rand_op());
      end
      default: cyc(8, 1'($urandom), z, rand_op());
    endcase
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = '0;
  endtask

  task automatic test_reset();
    logic [14:0] e;
    rst = 1'b1; r_mem_ready = 1'b1; r_zero = 1'b1; r_opcode = rand_op();
    #2;
    n_checks++;
    if ({w_mem_req, w_ir_write, w_pc_write, w_mem_write, w_reg_write} !== 5'b0) begin
      n_fails++; $display("FAIL reset_strobes: got %b expected 00000",
                          {w_mem_req, w_ir_write, w_pc_write, w_mem_write, w_reg_write});
    end
    @(posedge clk); #1;
    e = exp_ctrl(0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (w_ctrl !== e) begin
      n_fails++; $display("FAIL reset_ctrl: got %b expected %b", w_ctrl, e);
    end
    n_checks++;
    if (w_state !== 4'd0 || w_count !== 32'd0 || w4_count !== 4'd0) begin
      n_fails++; $display("FAIL reset_state: got state %0d count %0d/%0d expected 0 0/0",
                          w_state, w_count, w4_count);
    end
    rst = 1'b0;
    exp_count = '0;
  endtask

  task automatic test_lw();
    int t0;
    rw_cycles = 0;
    t0 = int'($time);
    run_instr(0, 1'b0, 0, 0);
    n_checks++;
    if ((int'($time) - t0) != 50 || rw_cycles != 1 || w_count !== 32'd1) begin
      n_fails++; $display("FAIL lw_summary: got %0d ns, %0d reg_write cycles, count %0d expected 50, 1, 1",
                          int'($time) - t0, rw_cycles, w_count);
    end
  endtask

  task automatic test_sw_wait();
    int t0;
    mw_cycles = 0; rw_cycles = 0;
    t0 = int'($time);
    run_instr(1, 1'b0, 0, 2);
    n_checks++;
    if (mw_cycles != 3 || rw_cycles != 0 || (int'($time) - t0) != 60) begin
      n_fails++; $display("FAIL sw_wait: got mem_write %0d, reg_write %0d, %0d ns expected 3, 0, 60",
                          mw_cycles, rw_cycles, int'($time) - t0);
    end
  endtask

  task automatic test_rtype_beq();
    pulse_reset();
    run_instr(2, 1'b0, 0, 0);
    run_instr(3, 1'b1, 0, 0);
    run_instr(3, 1'b0, 0, 0);
    n_checks++;
    if (w_count !== 32'd3) begin
      n_fails++; $display("FAIL rtype_beq_count: got %0d expected 3", w_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_trap();
    logic [31:0] frozen;
    logic [14:0] e;
    cyc(0, 1'b1, 1'b0, rand_op());
    cyc(1, 1'b1, 1'b0, 7'b0010111);
    frozen = exp_count;
    for (int i = 0; i < 20; i++) cyc(15, 1'($urandom), 1'($urandom), rand_op());
    n_checks++;
    if (w_count !== frozen) begin
      n_fails++; $display("FAIL trap_frozen: got %0d expected %0d", w_count, frozen);
    end
    rst = 1'b1; r_mem_ready = 1'b1;
    #1;
    e = exp_ctrl(15, 1'b1, r_zero, 1'b1);
    n_checks++;
    if (w_ctrl !== e) begin
      n_fails++; $display("FAIL trap_in_reset: got %b expected %b", w_ctrl, e);
    end
    @(posedge clk); #1;
    rst = 1'b0; exp_count = '0;
    cyc(0, 1'b0, 1'b0, rand_op());
  endtask

  task automatic test_reset_midinstr();
    logic [14:0] e;
    run_instr(2, 1'b0, 0, 0);
    cyc(0, 1'b1, 1'b0, rand_op());
    cyc(1, 1'b0, 1'b0, c_OP_SW);
    cyc(2, 1'b0, 1'b0, c_OP_SW);
    cyc(5, 1'b0, 1'b0, rand_op());
    r_mem_ready = 1'b0; rst = 1'b1;
    #1;
    e = exp_ctrl(5, 1'b0, r_zero, 1'b1);
    n_checks++;
    if (w_ctrl !== e || w_mem_write !== 1'b0) begin
      n_fails++; $display("FAIL reset_memwrite: got %b expected %b", w_ctrl, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (w_state !== 4'd0 || w_count !== 32'd0) begin
      n_fails++; $display("FAIL reset_mid_after: got state %0d count %0d expected 0 0", w_state, w_count);
    end
    rst = 1'b0; exp_count = '0;
  endtask

  task automatic test_count_wrap();
    pulse_reset();
    for (int i = 0; i < 15; i++) run_instr(2, 1'b0, 0, 0);
    n_checks++;
    if (w4_count !== 4'd15) begin
      n_fails++; $display("FAIL wrap_pre: got %0d expected 15", w4_count);
    end
    run_instr(2, 1'b0, 0, 0);
    n_checks++;
    if (w4_count !== 4'd0 || w_count !== 32'd16) begin
      n_fails++; $display("FAIL wrap_post: got %0d/%0d expected 0/16", w4_count, w_count);
    end
  endtask

  initial begin
    exp_count = '0; mw_cycles = 0; rw_cycles = 0;
    rst = 1'b1; r_opcode = '0; r_zero = 1'b0; r_mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype_beq();
    test_random();
    test_trap();
    test_reset_midinstr();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
